// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe: state encoding, shoe geometry, LFSR taps.
// Pure definitions; no latency or flow control of its own.
package card_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        DEST_P = 1'b0,
        DEST_D = 1'b1
    } dest_t;

    localparam int NUM_RANKS      = 10;
    localparam int SUITS_PER_RANK = 4;
    localparam int TEN_MULT       = 4;
    localparam int CARDS_PER_DECK = 52;
    localparam int CARD_W         = 5;
    localparam int IDX_W          = 4;
    localparam int CNT_W          = 8;
    localparam int LFSR_W         = 16;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [IDX_W-1:0] start_idx(input logic [IDX_W-1:0] r);
        return (r >= IDX_W'(NUM_RANKS)) ? r - IDX_W'(NUM_RANKS) : r;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_RANKS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Index NUM_RANKS-1 pools 10/J/Q/K, hence the extra multiplier.
    function automatic logic [CNT_W-1:0] rank_full(input int idx, input int decks);
        int n;
        n = SUITS_PER_RANK * decks;
        if (idx == NUM_RANKS - 1) begin
            n = n * TEN_MULT;
        end
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR, one step per clock, reset to SEED.
// Zero latency on the output nibble; never stalls.
module card_lfsr
    import card_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [IDX_W-1:0] o_rnd
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = r_lfsr >> 1;
        if (r_lfsr[0]) begin
            w_lfsr_nxt = w_lfsr_nxt ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign o_rnd = r_lfsr[IDX_W-1:0];

endmodule

// File: rtl/card_shoe.sv
// Shoe of NUM_DECKS decks dealing without replacement; valid pulses 1-10 cycles after a request is accepted.
// Requests are level-held and only sampled in IDLE; player wins ties, empty shoe ignores requests.
module card_shoe
    import card_pkg::*;
#(
    parameter int              NUM_DECKS = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              reset_n,
    input  logic              shuffle,
    input  logic              preq,
    input  logic              dreq,
    output logic [CARD_W-1:0] prandnumwire,
    output logic              pvalid,
    output logic [CARD_W-1:0] drandnumwire,
    output logic              dvalid,
    output logic              busy,
    output logic              empty,
    output logic [CNT_W-1:0]  cards_left
);

    localparam logic [CNT_W-1:0] SHOE_FULL = CNT_W'(CARDS_PER_DECK * NUM_DECKS);

    state_t            r_state;
    state_t            w_state_nxt;
    dest_t             r_dest;
    dest_t             w_accept_dest;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count [NUM_RANKS];
    logic [CNT_W-1:0]  r_cards_left;
    logic [CARD_W-1:0] r_pcard;
    logic [CARD_W-1:0] r_dcard;
    logic [IDX_W-1:0]  w_rnd;
    logic              w_accept;
    logic              w_hit;
    logic              w_empty;
    logic [CARD_W-1:0] w_card;

    card_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (Clock),
        .i_rst_n (reset_n),
        .o_rnd   (w_rnd)
    );

    assign w_empty = (r_cards_left == '0);
    assign w_card  = CARD_W'(r_idx) + CARD_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_accept_dest = DEST_P;
        w_hit         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && (preq || dreq)) begin
                    w_accept      = 1'b1;
                    w_accept_dest = preq ? DEST_P : DEST_D;
                    w_state_nxt   = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (r_count[r_idx] != '0) begin
                    w_hit       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A refill aborts whatever is in flight, including a hit this cycle.
        if (shuffle) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_hit       = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_dest <= DEST_P;
        end else if (w_accept) begin
            r_idx  <= start_idx(w_rnd);
            r_dest <= w_accept_dest;
        end else if (r_state == ST_PROBE && !w_hit) begin
            r_idx  <= next_idx(r_idx);
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                r_count[i] <= rank_full(i, NUM_DECKS);
            end
            r_cards_left <= SHOE_FULL;
        end else if (shuffle) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                r_count[i] <= rank_full(i, NUM_DECKS);
            end
            r_cards_left <= SHOE_FULL;
        end else if (w_hit) begin
            r_count[r_idx] <= r_count[r_idx] - CNT_W'(1);
            r_cards_left   <= r_cards_left - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pcard <= '0;
            r_dcard <= '0;
        end else if (w_hit) begin
            if (r_dest == DEST_P) begin
                r_pcard <= w_card;
            end else begin
                r_dcard <= w_card;
            end
        end
    end

    assign prandnumwire = r_pcard;
    assign drandnumwire = r_dcard;
    assign pvalid       = (r_state == ST_DONE) && (r_dest == DEST_P);
    assign dvalid       = (r_state == ST_DONE) && (r_dest == DEST_D);
    assign busy         = (r_state != ST_IDLE);
    assign empty        = w_empty;
    assign cards_left   = r_cards_left;

    a_single_valid: assert property (@(posedge Clock) disable iff (!reset_n)
        !(pvalid && dvalid));

    a_no_underflow: assert property (@(posedge Clock) disable iff (!reset_n)
        w_hit |-> (r_cards_left != '0));

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;

    logic       Clock;
    logic       reset_n;
    logic       shuffle, preq, dreq;
    logic [4:0] prandnumwire, drandnumwire;
    logic       pvalid, dvalid, busy, empty;
    logic [7:0] cards_left;

    logic       shuffle2, preq2, dreq2;
    logic [4:0] prand2, drand2;
    logic       pvalid2, dvalid2, busy2, empty2;
    logic [7:0] cards_left2;

    card_shoe #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1)) dut (
        .Clock(Clock), .reset_n(reset_n), .shuffle(shuffle), .preq(preq), .dreq(dreq),
        .prandnumwire(prandnumwire), .pvalid(pvalid), .drandnumwire(drandnumwire),
        .dvalid(dvalid), .busy(busy), .empty(empty), .cards_left(cards_left)
    );

    card_shoe #(.NUM_DECKS(2), .LFSR_SEED(16'h1234)) dut2 (
        .Clock(Clock), .reset_n(reset_n), .shuffle(shuffle2), .preq(preq2), .dreq(dreq2),
        .prandnumwire(prand2), .pvalid(pvalid2), .drandnumwire(drand2),
        .dvalid(dvalid2), .busy(busy2), .empty(empty2), .cards_left(cards_left2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        bit d;
        int cl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hist[11];
    int   last_p = 0;
    int   last_d = 0;
    int   model_left = 52;
    exp_t mon_e;
    int   mon_val;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endfunction

    // Monitor: every valid consumes one scoreboard entry.
    always @(negedge Clock) begin
        if (!reset_n) begin
            last_p = 0;
            last_d = 0;
        end else if (pvalid || dvalid) begin
            chk("one_valid_at_a_time", int'(pvalid && dvalid), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e   = sb_q.pop_front();
                mon_val = dvalid ? int'(drandnumwire) : int'(prandnumwire);
                chk("dest", int'(dvalid), int'(mon_e.d));
                chk("cards_left_at_valid", int'(cards_left), mon_e.cl);
                chk_rng("card_value", mon_val, 1, 10);
                if (dvalid) begin
                    chk("prand_holds", int'(prandnumwire), last_p);
                    last_d = mon_val;
                end else begin
                    chk("drand_holds", int'(drandnumwire), last_d);
                    last_p = mon_val;
                end
                if (mon_val >= 1 && mon_val <= 10) hist[mon_val]++;
            end
        end
    end

    task automatic wait_valid(input bit want_d, input int max_edges, output int lat);
        lat = 0;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge Clock); #1;
            if (want_d ? dvalid : pvalid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic deal_p(input string name);
        int lat;
        sb_q.push_back('{d: 1'b0, cl: model_left - 1});
        model_left--;
        preq = 1'b1;
        wait_valid(1'b0, 12, lat);
        preq = 1'b0;
        chk_rng(name, lat, 2, 11);
        if (lat == 0) begin
            void'(sb_q.pop_back());
            model_left++;
        end
        @(posedge Clock); #1;
    endtask

    task automatic do_shuffle(input string name);
        shuffle = 1'b1;
        @(posedge Clock); #1;
        shuffle = 1'b0;
        model_left = 52;
        chk({name, "_cards_left"}, int'(cards_left), 52);
        chk({name, "_empty"}, int'(empty), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, cl0, bad;
        int base[11];
        reset_n = 1'b0; shuffle = 1'b0; preq = 1'b0; dreq = 1'b0;
        shuffle2 = 1'b0; preq2 = 1'b0; dreq2 = 1'b0;
        for (int v = 0; v < 11; v++) hist[v] = 0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_cards_left", int'(cards_left), 52);
        chk("rst_cards_left_2deck", int'(cards_left2), 104);
        chk("rst_pvalid", int'(pvalid), 0);
        chk("rst_dvalid", int'(dvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_empty", int'(empty), 0);
        chk("rst_prand", int'(prandnumwire), 0);
        chk("rst_drand", int'(drandnumwire), 0);
        reset_n = 1'b1;
        @(posedge Clock); #1;

        // Single player request.
        deal_p("single_latency");
        chk("single_cards_left", int'(cards_left), 51);
        chk("single_drand_unchanged", int'(drandnumwire), 0);

        // Tie: player first, dealer follows once preq drops.
        cl0 = model_left;
        sb_q.push_back('{d: 1'b0, cl: cl0 - 1});
        sb_q.push_back('{d: 1'b1, cl: cl0 - 2});
        model_left = cl0 - 2;
        preq = 1'b1; dreq = 1'b1;
        wait_valid(1'b0, 12, lat);
        preq = 1'b0;
        chk_rng("tie_pvalid_latency", lat, 2, 11);
        wait_valid(1'b1, 13, lat);
        dreq = 1'b0;
        chk_rng("tie_dvalid_latency", lat, 1, 13);
        @(posedge Clock); #1;
        chk("tie_cards_left", int'(cards_left), cl0 - 2);
        if (sb_q.size() != 0) sb_q.delete();

        // Bring the shoe to 30 dealt, then shuffle mid-probe.
        while (model_left > 22) deal_p("pre_abort_latency");
        chk("after_30_cards_left", int'(cards_left), 22);
        preq = 1'b1;
        @(posedge Clock); #1;
        chk("abort_in_probe_busy", int'(busy), 1);
        shuffle = 1'b1;
        preq = 1'b0;
        @(posedge Clock); #1;
        shuffle = 1'b0;
        model_left = 52;
        chk("abort_cards_left", int'(cards_left), 52);
        chk("abort_busy", int'(busy), 0);
        bad = 0;
        repeat (15) begin
            @(posedge Clock); #1;
            if (pvalid || dvalid) bad++;
        end
        chk("abort_no_valid", bad, 0);

        // Full drain: the tail exercises exhausted-rank probe walks.
        for (int v = 0; v < 11; v++) base[v] = hist[v];
        for (int n = 0; n < 52; n++) deal_p("drain_latency");
        for (int v = 1; v <= 9; v++) chk($sformatf("hist_value_%0d", v), hist[v] - base[v], 4);
        chk("hist_value_10", hist[10] - base[10], 16);
        chk("drain_empty", int'(empty), 1);
        chk("drain_cards_left", int'(cards_left), 0);
        preq = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge Clock); #1;
            if (pvalid || busy) bad++;
        end
        preq = 1'b0;
        chk("empty_ignores_req", bad, 0);
        do_shuffle("refill");

        // Two-deck shoe.
        preq2 = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clock); #1;
            if (pvalid2) begin
                lat = i;
                break;
            end
        end
        chk_rng("deck2_value", int'(prand2), 1, 10);
        preq2 = 1'b0;
        chk_rng("deck2_latency", lat, 2, 11);
        chk("deck2_cards_left", int'(cards_left2), 103);

        // Async reset in the middle of a deal.
        deal_p("pre_reset_latency");
        preq = 1'b1;
        @(posedge Clock); #1;
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_cards_left", int'(cards_left), 52);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_pvalid", int'(pvalid), 0);
        chk("midreset_prand", int'(prandnumwire), 0);
        chk("midreset_empty", int'(empty), 0);
        preq = 1'b0;
        model_left = 52;
        @(posedge Clock); #1;
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge Clock); #1;
            if (pvalid || dvalid) bad++;
        end
        chk("post_reset_no_valid", bad, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
